// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : 8N1 asynchronous serial receiver.
//
// Deserialises the rx line into bytes and hands them to a downstream consumer
// over a valid/ready handshake. Stop-bit failures and bytes lost because the
// consumer was still holding the previous one are reported as errors.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (4..65535)
//   SYNC_STAGES   flops in the rx input synchroniser (2..3)
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   rx           in   serial line, idles high
//   data[7:0]    out  received byte, stable while valid is high
//   valid        out  byte available
//   ready        in   consumer accepts byte (transfer on valid && ready)
//   busy         out  receiver is inside a frame (FSM not idle)
//   frame_error  out  one-cycle pulse when a stop bit samples low
//   overrun      out  sticky: a byte completed while valid was still high
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_error,
    output logic       overrun
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Half-period load lands the start-bit sample mid-bit; every later sample
    // is one full period after the previous one.
    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_s;

    state_t      state_r,       state_nxt_s;
    logic [15:0] cnt_r,         cnt_nxt_s;
    logic [2:0]  bit_idx_r,     bit_idx_nxt_s;
    logic [7:0]  shift_r,       shift_nxt_s;
    logic [7:0]  data_r,        data_nxt_s;
    logic        valid_r,       valid_nxt_s;
    logic        overrun_r,     overrun_nxt_s;
    logic        frame_error_r, frame_error_nxt_s;
    logic        busy_r,        busy_nxt_s;
    logic        handshake_s;

    // Input synchroniser; flops reset to the idle (high) line level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_r[SYNC_STAGES-1];

    // State and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 16'd0;
            bit_idx_r     <= 3'd0;
            shift_r       <= 8'h00;
            data_r        <= 8'h00;
            valid_r       <= 1'b0;
            overrun_r     <= 1'b0;
            frame_error_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            bit_idx_r     <= bit_idx_nxt_s;
            shift_r       <= shift_nxt_s;
            data_r        <= data_nxt_s;
            valid_r       <= valid_nxt_s;
            overrun_r     <= overrun_nxt_s;
            frame_error_r <= frame_error_nxt_s;
            busy_r        <= busy_nxt_s;
        end
    end

    assign handshake_s = valid_r & ready;

    // Next-state, bit timing, byte delivery and error flags.
    always_comb begin
        state_nxt_s       = state_r;
        cnt_nxt_s         = cnt_r;
        bit_idx_nxt_s     = bit_idx_r;
        shift_nxt_s       = shift_r;
        data_nxt_s        = data_r;
        valid_nxt_s       = valid_r;
        overrun_nxt_s     = overrun_r;
        frame_error_nxt_s = 1'b0;

        // A completed transfer frees the output register and clears overrun;
        // a byte finishing in this same cycle may refill it below.
        if (handshake_s) begin
            valid_nxt_s   = 1'b0;
            overrun_nxt_s = 1'b0;
        end else begin
            valid_nxt_s   = valid_r;
            overrun_nxt_s = overrun_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_nxt_s   = HALF_LOAD;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == 16'd0) begin
                    if (!rx_s) begin
                        cnt_nxt_s     = FULL_LOAD;
                        bit_idx_nxt_s = 3'd0;
                        state_nxt_s   = ST_DATA;
                    end else begin
                        // Line is high again at mid start bit: a glitch.
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_r == 16'd0) begin
                    shift_nxt_s   = {rx_s, shift_r[7:1]};
                    cnt_nxt_s     = FULL_LOAD;
                    bit_idx_nxt_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_r == 16'd0) begin
                    if (rx_s) begin
                        if (!valid_r || handshake_s) begin
                            data_nxt_s  = shift_r;
                            valid_nxt_s = 1'b1;
                        end else begin
                            // Consumer still holds the previous byte.
                            overrun_nxt_s = 1'b1;
                        end
                        state_nxt_s = ST_IDLE;
                    end else begin
                        frame_error_nxt_s = 1'b1;
                        state_nxt_s       = ST_BREAK;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            ST_BREAK: begin
                // Wait out a held-low line so a break yields a single error.
                if (rx_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BREAK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    assign data        = data_r;
    assign valid       = valid_r;
    assign busy        = busy_r;
    assign frame_error = frame_error_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx (CLKS_PER_BIT=16, SYNC_STAGES=2).
// Expected bytes are queued as frames are driven; a monitor collects bytes that
// cross the valid/ready handshake, and each scenario task pops and compares.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       frame_error;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rxq[$];
    int         fe_count     = 0;
    int         valid_cycles = 0;
    int         cyc          = 0;
    int         rise_cyc     = 0;
    bit         prev_valid   = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clock       (clk),
        .reset       (rst_n),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .busy        (busy),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: captures handshaken bytes, error pulses and valid activity.
    always @(negedge clk) begin
        #1;
        if (rst_n === 1'b1) begin
            if (valid === 1'b1 && ready === 1'b1) rxq.push_back(data);
            if (frame_error === 1'b1) fe_count++;
            if (valid === 1'b1) valid_cycles++;
            if (valid === 1'b1 && !prev_valid) rise_cyc = cyc;
        end
        prev_valid = (valid === 1'b1);
    end

    // Drive one 8N1 frame; called and returns on a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // Bounded wait until the monitor holds at least n bytes.
    task automatic wait_rx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rxq.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({data, valid, busy, frame_error, overrun} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%h valid=%b busy=%b fe=%b ovr=%b, want all 0",
                     data, valid, busy, frame_error, overrun);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_single;
        bit ok;
        int v0, f0, start_cyc, lat;
        logic [7:0] got, exp;
        v0 = valid_cycles;
        f0 = fe_count;
        exp_q.push_back(8'hA5);
        start_cyc = cyc;
        send_byte(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        wait_rx(1, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_timeout: got %0d bytes, want 1", rxq.size());
        end else begin
            got = rxq.pop_front();
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL single_data: got %h, want %h", got, exp);
            end
        end
        lat = rise_cyc - start_cyc;
        vectors++;
        if (lat < 154 || lat > 156) begin
            miscompares++;
            $display("FAIL single_latency: got %0d cycles, want 155 +/-1", lat);
        end
        vectors++;
        if (valid_cycles - v0 != 1) begin
            miscompares++;
            $display("FAIL single_valid_cycles: got %0d, want 1", valid_cycles - v0);
        end
        vectors++;
        if (fe_count != f0 || overrun !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_flags: got fe=%0d ovr=%b busy=%b, want 0 0 0",
                     fe_count - f0, overrun, busy);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int f0;
        logic [7:0] got, exp;
        logic [7:0] pat[3];
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'h3C;
        f0 = fe_count;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pat[i]);
            send_byte(pat[i], 1'b1);
        end
        repeat (10) @(negedge clk);
        wait_rx(3, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d bytes, want 3", rxq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got = rxq.pop_front();
                exp = exp_q.pop_front();
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_data%0d: got %h, want %h", i, got, exp);
                end
            end
        end
        vectors++;
        if (fe_count != f0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_flags: got fe=%0d ovr=%b, want 0 0", fe_count - f0, overrun);
        end
    endtask

    task automatic test_glitch;
        int f0;
        f0 = fe_count;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_busy_start: got %b, want 1", busy);
        end
        rx = 1'b1;
        repeat (30) @(negedge clk);
        vectors++;
        if (valid !== 1'b0 || busy !== 1'b0 || fe_count != f0 || rxq.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_idle: got valid=%b busy=%b fe=%0d bytes=%0d, want 0 0 0 0",
                     valid, busy, fe_count - f0, rxq.size());
        end
    endtask

    task automatic test_framing;
        int f0;
        f0 = fe_count;
        send_byte(8'h55, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        vectors++;
        if (fe_count - f0 != 1 || valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL framing_break: got fe=%0d valid=%b busy=%b, want 1 0 1",
                     fe_count - f0, valid, busy);
        end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (fe_count - f0 != 1 || busy !== 1'b0 || rxq.size() != 0) begin
            miscompares++;
            $display("FAIL framing_release: got fe=%0d busy=%b bytes=%0d, want 1 0 0",
                     fe_count - f0, busy, rxq.size());
        end
    endtask

    task automatic test_overrun;
        logic [7:0] got, exp;
        ready = 1'b0;
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (5) @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || data !== 8'h12 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got valid=%b data=%h ovr=%b, want 1 12 1",
                     valid, data, overrun);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (valid !== 1'b0 || overrun !== 1'b0 || data !== 8'h12) begin
            miscompares++;
            $display("FAIL overrun_clear: got valid=%b ovr=%b data=%h, want 0 0 12",
                     valid, overrun, data);
        end
        vectors++;
        if (rxq.size() != 1) begin
            miscompares++;
            $display("FAIL overrun_count: got %0d bytes, want 1", rxq.size());
        end else begin
            got = rxq.pop_front();
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL overrun_data: got %h, want %h", got, exp);
            end
        end
        ready = 1'b1;
        repeat (40) @(negedge clk);
        vectors++;
        if (rxq.size() != 0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_dropped: got bytes=%0d valid=%b, want 0 0", rxq.size(), valid);
        end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        logic [7:0] got, exp;
        logic [7:0] b;
        b  = 8'hC3;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[3];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        vectors++;
        if ({data, valid, busy, frame_error, overrun} !== 12'h000) begin
            miscompares++;
            $display("FAIL midreset_outputs: got data=%h valid=%b busy=%b fe=%b ovr=%b, want all 0",
                     data, valid, busy, frame_error, overrun);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 1'b1);
        repeat (10) @(negedge clk);
        wait_rx(1, ok);
        vectors++;
        if (!ok || rxq.size() != 1) begin
            miscompares++;
            $display("FAIL midreset_count: got %0d bytes, want 1", rxq.size());
        end else begin
            got = rxq.pop_front();
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL midreset_data: got %h, want %h", got, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expected: got %0d unreceived bytes, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver.
- Deserialises an asynchronous 8N1 serial line into bytes for the UART datapath.
- Sits directly upstream of the byte consumer (FIFO or command decoder).
- Delivers each byte on a valid/ready handshake and reports framing and overrun errors.

Parameters:
- CLKS_PER_BIT, default 104, clock cycles per bit period (12 MHz / 115200 baud); legal range 4..65535.
- SYNC_STAGES, default 2, flip-flops in the rx input synchroniser; legal range 2..3.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high.
- data  output  8  received byte; stable while valid is high.
- valid  output  1  byte available.
- ready  input  1  consumer accepts the byte; transfer occurs when valid && ready on a clock edge.
- busy  output  1  high while the FSM is not IDLE.
- frame_error  output  1  one-cycle pulse when a stop bit samples low.
- overrun  output  1  sticky flag: a byte completed while valid was still high.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; synchroniser flops=1; bit counter=0; cycle counter=0.
  - data=8'h00; valid=0; busy=0; frame_error=0; overrun=0.
  - Reset mid-frame abandons the frame with no output. After release, the receiver waits for a fresh falling edge.
- Synchroniser:
  - rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - When rx_s==0: load cycle counter with CLKS_PER_BIT/2 - 1 (integer division) and go to START.
- START:
  - Count down. At 0, sample rx_s.
  - If rx_s==0: go to DATA, load cycle counter with CLKS_PER_BIT-1, bit index=0.
  - If rx_s==1: false start (glitch); go to IDLE with no output.
- DATA:
  - Count down. At 0, shift rx_s into the shift register LSB-first and reload CLKS_PER_BIT-1.
  - After the 8th sample (bit index 7), go to STOP.
- STOP:
  - Count down. At 0, sample rx_s.
  - rx_s==1, valid low: data<=shift register and valid<=1 on the next edge; go to IDLE.
  - rx_s==1, valid high: data is unchanged, the new byte is dropped, overrun<=1; go to IDLE.
  - rx_s==0: frame_error pulses high for exactly one cycle, the byte is discarded, valid and data are unchanged; go to BREAK.
- BREAK:
  - Stay until rx_s==1, then go to IDLE. A held-low line (break) therefore produces one frame_error, not repeated frames.
- Sampling:
  - All samples land at mid-bit (±1 cycle).
  - A new start edge is accepted in the cycle after returning to IDLE, so back-to-back frames with a one-bit stop are received without loss.
- Handshake:
  - valid stays high and data stays stable until a cycle with valid && ready.
  - valid drops on the following edge.
  - ready while valid==0 has no effect.
  - Handshake and a new byte completing in the same cycle: the new byte is loaded and valid stays 1, no overrun.
- overrun:
  - Cleared only by reset or by a completed handshake. A handshake in the same cycle that sets overrun takes priority for clearing. The dropped byte is never recovered.
- Latency:
  - valid rises CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + SYNC_STAGES + 1 cycles (±1) after the falling edge of the start bit on rx.
- busy:
  - busy=1 in START, DATA, STOP and BREAK.
- Widths:
  - Cycle counter is 16 bits.
  - Bit index is 3 bits; wrap-around at 7 is the transition to STOP, not an error.

Test Plan:
- Bench settings: CLKS_PER_BIT=16, SYNC_STAGES=2, 10 ns clock, ready held high unless stated.
- Single byte: drive 8'hA5 as 8N1 at 16 clocks per bit -> one valid cycle with data=8'hA5, frame_error=0, overrun=0, busy low after STOP.
- Back-to-back: send 8'h00, 8'hFF, 8'h3C with no idle gap beyond one stop bit -> three handshakes, bytes in order, no errors.
- Glitch: pull rx low for 4 cycles, then high -> FSM returns to IDLE from START; valid, frame_error and busy all low afterwards.
- Framing: send 8'h55 with stop bit low, then hold rx low for 40 cycles -> exactly one frame_error pulse, valid=0, busy=1 until rx returns high.
- Overrun: ready=0; send 8'h12 then 8'h34 -> data=8'h12, valid=1, overrun=1. Raise ready for one cycle -> valid=0, overrun=0, 8'h34 never appears.
- Reset mid-frame: assert reset low during bit 3 of 8'hC3, release, then send 8'h7E -> no output for 8'hC3; 8'h7E received correctly; all outputs 0 while reset is low.
